// File: rtl/mean_filter_mc_pkg.sv
// Shared constants and sizing helpers for the multi-channel moving-average filter.
package mean_filter_mc_pkg;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_LOG2_DEPTH = 3;
  localparam int unsigned DEF_CH_NUM     = 4;
  localparam int unsigned DEF_CH_W       = 2;
  localparam int unsigned DEF_ROUND      = 0;

  // Samples held per channel window.
  function automatic int unsigned calc_depth(input int unsigned log2_depth);
    return 32'd1 << log2_depth;
  endfunction

  // Accumulator width: a full window of maximum samples never overflows.
  function automatic int unsigned calc_acc_w(input int unsigned data_w,
                                             input int unsigned log2_depth);
    return data_w + log2_depth;
  endfunction

  // Sample RAM address is {channel, slot}.
  function automatic int unsigned calc_ram_aw(input int unsigned ch_w,
                                              input int unsigned log2_depth);
    return ch_w + log2_depth;
  endfunction

  // Half an LSB of the mean, added before the shift for round half-up.
  function automatic int unsigned round_bias(input int unsigned log2_depth);
    return 32'd1 << (log2_depth - 1);
  endfunction

endpackage

// File: rtl/mean_filter_mc_if.sv
// Sample-in / mean-out bus of the multi-channel mean filter, plus its control strobes.
interface mean_filter_mc_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH_W   = 2
) ();

  logic              clr;
  logic              pass_fill;
  logic              in_vld;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              out_vld;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic              out_full;

  modport master (
    output clr, pass_fill, in_vld, in_ch, in_data,
    input  out_vld, out_ch, out_data, out_full
  );

  modport slave (
    input  clr, pass_fill, in_vld, in_ch, in_data,
    output out_vld, out_ch, out_data, out_full
  );

endinterface

// File: rtl/mean_mc_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, array not reset.
module mean_mc_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 5,
  parameter int unsigned WORDS  = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;
  logic              w_unused_addr;

  // Addresses are always below WORDS, so the upper tag bits may be dropped.
  assign w_unused_addr = ^{i_waddr, i_raddr};

  // Write port and synchronous read port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr[IDX_W-1:0]];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mean_filter_mc.sv
// Multi-channel moving-average filter: channel-tagged samples share one window RAM,
// one mean per accepted sample, two-cycle latency, full throughput.
module mean_filter_mc
  import mean_filter_mc_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int unsigned CH_NUM     = DEF_CH_NUM,
  parameter int unsigned CH_W       = DEF_CH_W,
  parameter int unsigned ROUND      = DEF_ROUND
) (
  input logic             clk,
  input logic             rst_n,
  mean_filter_mc_if.slave bus
);

  localparam int unsigned DEPTH    = calc_depth(LOG2_DEPTH);
  localparam int unsigned ACC_W    = calc_acc_w(DATA_W, LOG2_DEPTH);
  localparam int unsigned RAM_AW   = calc_ram_aw(CH_W, LOG2_DEPTH);
  localparam int unsigned FILL_W   = LOG2_DEPTH + 1;
  localparam int unsigned CH_SLOTS = 1 << CH_W;
  localparam int unsigned RND      = round_bias(LOG2_DEPTH);
  localparam int unsigned DEPTH_M1 = DEPTH - 1;

  localparam logic [FILL_W-1:0] FILL_MAX  = DEPTH[FILL_W-1:0];
  localparam logic [FILL_W-1:0] FILL_LAST = DEPTH_M1[FILL_W-1:0];
  localparam logic [CH_W:0]     CH_LIM    = CH_NUM[CH_W:0];
  localparam logic [ACC_W:0]    RND_C     = RND[ACC_W:0];

  // Per-channel state; slots for tags >= CH_NUM exist but are never written.
  logic [LOG2_DEPTH-1:0] r_wr_ptr [CH_SLOTS];
  logic [FILL_W-1:0]     r_fill   [CH_SLOTS];
  logic [ACC_W-1:0]      r_acc    [CH_SLOTS];

  logic                  w_accept;
  logic [FILL_W-1:0]     w_fill_cur;
  logic                  w_full_now;
  logic                  w_win_full;
  logic [RAM_AW-1:0]     w_rd_addr;

  logic                  r_p1_vld;
  logic                  r_p1_old_vld;
  logic                  r_p1_emit;
  logic                  r_p1_win_full;
  logic [CH_W-1:0]       r_p1_ch;
  logic [DATA_W-1:0]     r_p1_data;
  logic [RAM_AW-1:0]     r_p1_addr;

  logic [DATA_W-1:0]     w_rd_data;
  logic [DATA_W-1:0]     w_old;
  logic [ACC_W-1:0]      w_acc_new;
  logic [ACC_W:0]        w_sum_rnd;
  logic [DATA_W-1:0]     w_mean;
  logic                  w_unused_frac;

  logic                  r_out_vld;
  logic [CH_W-1:0]       r_out_ch;
  logic [DATA_W-1:0]     r_out_data;
  logic                  r_out_full;

  // Stage 0: accept the sample and look up its channel state.
  always_comb begin
    w_accept   = bus.in_vld && ({1'b0, bus.in_ch} < CH_LIM) && !bus.clr;
    w_fill_cur = r_fill[bus.in_ch];
    w_full_now = (w_fill_cur == FILL_MAX);
    w_win_full = (w_fill_cur >= FILL_LAST);
    w_rd_addr  = {bus.in_ch, r_wr_ptr[bus.in_ch]};
  end

  mean_mc_ram #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW),
    .WORDS  (CH_NUM * DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (r_p1_vld),
    .i_waddr (r_p1_addr),
    .i_wdata (r_p1_data),
    .i_re    (w_accept),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Stage 1: slide the window sum and derive the mean.
  always_comb begin
    // RAM slots of a filling window hold stale data and must not be subtracted.
    w_old     = r_p1_old_vld ? w_rd_data : '0;
    w_acc_new = r_acc[r_p1_ch] + {{LOG2_DEPTH{1'b0}}, r_p1_data}
                - {{LOG2_DEPTH{1'b0}}, w_old};
    w_sum_rnd = {1'b0, w_acc_new} + RND_C;
    if (ROUND != 0) begin
      w_mean = w_sum_rnd[ACC_W] ? '1 : w_sum_rnd[ACC_W-1:LOG2_DEPTH];
    end else begin
      w_mean = w_acc_new[ACC_W-1:LOG2_DEPTH];
    end
    w_unused_frac = ^w_sum_rnd[LOG2_DEPTH-1:0];
  end

  // Per-channel pointer, fill count and accumulator; clr wipes them all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_SLOTS; i++) begin
        r_wr_ptr[i] <= '0;
        r_fill[i]   <= '0;
        r_acc[i]    <= '0;
      end
    end else if (bus.clr) begin
      for (int i = 0; i < CH_SLOTS; i++) begin
        r_wr_ptr[i] <= '0;
        r_fill[i]   <= '0;
        r_acc[i]    <= '0;
      end
    end else begin
      if (w_accept) begin
        r_wr_ptr[bus.in_ch] <= r_wr_ptr[bus.in_ch] + 1'b1;
        if (!w_full_now) begin
          r_fill[bus.in_ch] <= w_fill_cur + 1'b1;
        end
      end
      if (r_p1_vld) begin
        r_acc[r_p1_ch] <= w_acc_new;
      end
    end
  end

  // Stage 0 -> 1 pipeline register; w_accept is already low during clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_vld      <= 1'b0;
      r_p1_old_vld  <= 1'b0;
      r_p1_emit     <= 1'b0;
      r_p1_win_full <= 1'b0;
      r_p1_ch       <= '0;
      r_p1_data     <= '0;
      r_p1_addr     <= '0;
    end else begin
      r_p1_vld <= w_accept;
      if (w_accept) begin
        r_p1_old_vld  <= w_full_now;
        r_p1_emit     <= w_win_full || bus.pass_fill;
        r_p1_win_full <= w_win_full;
        r_p1_ch       <= bus.in_ch;
        r_p1_data     <= bus.in_data;
        r_p1_addr     <= w_rd_addr;
      end
    end
  end

  // Stage 2 output register; data and tag hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_ch   <= '0;
      r_out_data <= '0;
      r_out_full <= 1'b0;
    end else if (bus.clr) begin
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= r_p1_vld && r_p1_emit;
      if (r_p1_vld && r_p1_emit) begin
        r_out_ch   <= r_p1_ch;
        r_out_data <= w_mean;
        r_out_full <= r_p1_win_full;
      end
    end
  end

  assign bus.out_vld  = r_out_vld;
  assign bus.out_ch   = r_out_ch;
  assign bus.out_data = r_out_data;
  assign bus.out_full = r_out_full;

endmodule

// File: tb/tb_mean_filter_mc.sv
// Bench for mean_filter_mc: truncating and rounding instances driven in lockstep,
// expected means queued at drive time and matched against the output strobes.
module tb_mean_filter_mc;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] data;
    logic       pf;
    logic       ev;
    logic [7:0] e0;
    logic [7:0] e1;
    logic       ef;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [2:0] ch;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       full;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  vec_t tbl[$];
  exp_t q[$];
  exp_t m_e;

  mean_filter_mc_if #(.DATA_W(8), .CH_W(3)) if0 ();
  mean_filter_mc_if #(.DATA_W(8), .CH_W(3)) if1 ();

  mean_filter_mc #(
    .DATA_W(8), .LOG2_DEPTH(3), .CH_NUM(4), .CH_W(3), .ROUND(0)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  mean_filter_mc #(
    .DATA_W(8), .LOG2_DEPTH(3), .CH_NUM(4), .CH_W(3), .ROUND(1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void add_vec(input logic [2:0] ch, input logic [7:0] data,
                                  input logic pf, input logic ev, input logic [7:0] e0,
                                  input logic [7:0] e1, input logic ef);
    vec_t v;
    v.ch = ch; v.data = data; v.pf = pf; v.ev = ev; v.e0 = e0; v.e1 = e1; v.ef = ef;
    tbl.push_back(v);
  endfunction

  function automatic void expect_out(input logic [2:0] ch, input logic [7:0] d0,
                                     input logic [7:0] d1, input logic full);
    exp_t e;
    e.cyc = cyc + 2; e.ch = ch; e.d0 = d0; e.d1 = d1; e.full = full;
    q.push_back(e);
  endfunction

  task automatic set_in(input logic v, input logic [2:0] ch, input logic [7:0] d,
                        input logic pf, input logic c);
    if0.in_vld = v; if0.in_ch = ch; if0.in_data = d; if0.pass_fill = pf; if0.clr = c;
    if1.in_vld = v; if1.in_ch = ch; if1.in_data = d; if1.pass_fill = pf; if1.clr = c;
  endtask

  task automatic drive(input logic v, input logic [2:0] ch, input logic [7:0] d,
                       input logic pf, input logic c);
    @(negedge clk);
    set_in(v, ch, d, pf, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
  endtask

  // Every cycle: either the scheduled result appears, or both outputs stay quiet.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        m_e = q.pop_front();
        chk("out_rnd0", {3'b0, if0.out_vld, if0.out_ch, if0.out_data, if0.out_full},
            {3'b0, 1'b1, m_e.ch, m_e.d0, m_e.full});
        chk("out_rnd1", {3'b0, if1.out_vld, if1.out_ch, if1.out_data, if1.out_full},
            {3'b0, 1'b1, m_e.ch, m_e.d1, m_e.full});
      end else begin
        chk("quiet_rnd0", {15'b0, if0.out_vld}, 16'h0);
        chk("quiet_rnd1", {15'b0, if1.out_vld}, 16'h0);
      end
    end
  end

  initial begin
    logic [2:0] ch;
    logic [7:0] v;
    int k0, k1, kk, s, r;

    set_in(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);

    // ch0 x10 of 100, fill suppressed: only samples 8..10 emit.
    for (int i = 1; i <= 10; i++) add_vec(3'd0, 8'd100, 1'b0, i >= 8, 8'd100, 8'd100, 1'b1);
    // Out-of-range tags are dropped; tag 5 must not alias onto ch1.
    add_vec(3'd5, 8'd77, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    add_vec(3'd4, 8'd200, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    // ch2 x8 of 8 with fill pass-through: means 1..8, full on the 8th.
    for (int i = 1; i <= 8; i++) add_vec(3'd2, 8'd8, 1'b1, 1'b1, 8'(i), 8'(i), i == 8);
    // ch1: seven zeros then 4 -> sum 4: truncated 0, rounded 1.
    for (int i = 1; i <= 7; i++) add_vec(3'd1, 8'd0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0);
    add_vec(3'd1, 8'd4, 1'b1, 1'b1, 8'd0, 8'd1, 1'b1);
    // ch3 x9 of 255: no accumulator or rounding wrap.
    for (int i = 1; i <= 9; i++) add_vec(3'd3, 8'd255, 1'b0, i >= 8, 8'd255, 8'd255, 1'b1);

    repeat (2) @(negedge clk);
    chk("reset_rnd0", {3'b0, if0.out_vld, if0.out_ch, if0.out_data, if0.out_full}, 16'h0);
    chk("reset_rnd1", {3'b0, if1.out_vld, if1.out_ch, if1.out_data, if1.out_full}, 16'h0);
    rst_n = 1'b1;
    idle(2);

    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].ch, tbl[i].data, tbl[i].pf, 1'b0);
      if (tbl[i].ev) expect_out(tbl[i].ch, tbl[i].e0, tbl[i].e1, tbl[i].ef);
    end
    idle(3);

    // clr on an idle pipeline: strobe stays low, last result held.
    drive(1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
    chk("clr_hold0", {3'b0, if0.out_vld, if0.out_ch, if0.out_data, if0.out_full},
        {3'b0, 1'b0, 3'd3, 8'd255, 1'b1});
    chk("clr_hold1", {3'b0, if1.out_vld, if1.out_ch, if1.out_data, if1.out_full},
        {3'b0, 1'b0, 3'd3, 8'd255, 1'b1});

    // Interleave ch0=200 / ch1=40 every cycle: a strobe per sample, sum over DEPTH.
    k0 = 0;
    k1 = 0;
    for (int i = 0; i < 24; i++) begin
      ch = (i % 2 == 0) ? 3'd0 : 3'd1;
      v  = (ch == 3'd0) ? 8'd200 : 8'd40;
      if (ch == 3'd0) begin k0++; kk = k0; end else begin k1++; kk = k1; end
      s = ((kk > 8) ? 8 : kk) * int'(v);
      r = (s + 4) >> 3;
      if (r > 255) r = 255;
      drive(1'b1, ch, v, 1'b1, 1'b0);
      expect_out(ch, 8'(s >> 3), 8'(r), kk >= 8);
    end
    idle(3);

    // clr with one sample in stage 1 and one presented alongside clr: neither emits.
    drive(1'b1, 3'd0, 8'd9, 1'b1, 1'b0);
    drive(1'b1, 3'd0, 8'd9, 1'b1, 1'b1);
    idle(3);
    chk("clr_flight0", {3'b0, if0.out_vld, if0.out_ch, if0.out_data, if0.out_full},
        {3'b0, 1'b0, 3'd1, 8'd40, 1'b1});
    chk("clr_flight1", {3'b0, if1.out_vld, if1.out_ch, if1.out_data, if1.out_full},
        {3'b0, 1'b0, 3'd1, 8'd40, 1'b1});

    // ch0 refill after clr: eight fresh samples before the first full mean.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 3'd0, 8'd50, 1'b0, 1'b0);
      if (i == 8) expect_out(3'd0, 8'd50, 8'd50, 1'b1);
    end
    drive(1'b1, 3'd0, 8'd50, 1'b0, 1'b0);
    expect_out(3'd0, 8'd50, 8'd50, 1'b1);
    drive(1'b1, 3'd0, 8'd50, 1'b0, 1'b0);
    expect_out(3'd0, 8'd50, 8'd50, 1'b1);
    drive(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream, away from any clock edge.
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_rnd0", {3'b0, if0.out_vld, if0.out_ch, if0.out_data, if0.out_full}, 16'h0);
    chk("arst_rnd1", {3'b0, if1.out_vld, if1.out_ch, if1.out_data, if1.out_full}, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // After reset ch0 starts empty: 84/8 -> 10 truncated, 11 rounded.
    drive(1'b1, 3'd0, 8'd84, 1'b1, 1'b0);
    expect_out(3'd0, 8'd10, 8'd11, 1'b0);
    idle(4);

    chk("drained", 16'(q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
